// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues word reads to instruction memory,
// buffers returned instructions with their PCs and hands them to decode.
// A redirect flushes buffered and in-flight instructions and restarts fetch.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect halts
// fetch and sets a sticky error flag; otherwise redirect_pc[1:0] is ignored).
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        misalign_err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fq_entry_t;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     resp_pc_q, resp_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            imem_req_q, imem_req_d;
   logic            id_valid_q, id_valid_d;
   logic [31:0]     id_instr_q, id_instr_d;
   logic [31:0]     id_pc_q, id_pc_d;
   fq_entry_t       mem_q [DEPTH];

   logic            grant_c;
   logic            pop_c;
   logic            keep_c;
   logic            misalign_c;
   logic [31:0]     redir_pc_c;
   fq_entry_t       push_entry_c;
   fq_entry_t       head_c;

`ifdef FETCH_MISALIGN_CHECK_EN
   // Misaligned redirects are reported and halt fetch.
   assign redir_pc_c = redirect_pc;
   assign misalign_c = redirect && (redirect_pc[1:0] != 2'b00);
`else
   // Low address bits are dropped; the halt path is never taken.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^redirect_pc[1:0];
   assign redir_pc_c    = {redirect_pc[31:2], 2'b00};
   assign misalign_c    = 1'b0;
`endif

   assign grant_c      = imem_req_q && imem_gnt;
   assign pop_c        = id_valid_q && id_ready && !redirect;
   assign keep_c       = imem_rvalid && (discard_q == '0) && !redirect;
   assign push_entry_c = '{instr: imem_rdata, pc: resp_pc_q};

   // FSM next state and sticky misalignment flag.
   always_comb begin
      state_d    = state_q;
      misalign_d = misalign_q;
      case (state_q)
         S_RUN:   if (misalign_c) state_d = S_HALT;
         S_HALT:  if (redirect && !misalign_c) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
      if (misalign_c) misalign_d = 1'b1;
   end

   // Datapath next state: PCs, credits, FIFO pointers and registered outputs.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      head_c        = push_entry_c;

      outstanding_d = outstanding_q + CW'(grant_c) - CW'(imem_rvalid);
      count_d       = count_q + CW'(keep_c) - CW'(pop_c);

      if (grant_c) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (keep_c) begin
         resp_pc_d = resp_pc_q + 32'd4;
         wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);

      // Flush everything; every request still in flight becomes a discard.
      if (redirect) begin
         fetch_pc_d = redir_pc_c;
         resp_pc_d  = redir_pc_c;
         discard_d  = outstanding_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end

      // New head is either a stored entry or the word being pushed into an empty queue.
      if (!(keep_c && ((count_q - CW'(pop_c)) == '0))) head_c = mem_q[rd_ptr_d];
      if (count_d != '0) begin
         id_instr_d = head_c.instr;
         id_pc_d    = head_c.pc;
      end

      id_valid_d = (count_d != '0);
      imem_req_d = (state_d == S_RUN) && ((count_d + outstanding_d) < CW'(DEPTH));
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_RUN;
         misalign_q    <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         imem_req_q    <= 1'b0;
         id_valid_q    <= 1'b0;
         id_instr_q    <= '0;
         id_pc_q       <= '0;
      end else begin
         state_q       <= state_d;
         misalign_q    <= misalign_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         imem_req_q    <= imem_req_d;
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (keep_c) mem_q[wr_ptr_q] <= push_entry_c;
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = fetch_pc_q;
   assign id_valid     = id_valid_q;
   assign id_instr     = id_instr_q;
   assign id_pc        = id_pc_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with random latency and a
// queue-based reference of which fetched words must reach decode.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        misalign_err;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
   typedef struct { logic [31:0] pc; bit stale; } flight_t;

   mreq_t       mem_q[$];
   flight_t     infl[$];
   logic [31:0] mfifo[$];
   logic [31:0] popped[$];
   logic [31:0] dut_grants[$];
   logic [31:0] m_fetch_pc;
   bit          m_run, m_mis, fired;
   int unsigned cyc = 0, last_due = 0;
   int          min_lat = 1, max_lat = 1, gnt_pct = 100;
   int          checks = 0, errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] pop_at(input int k);
      return (k < popped.size()) ? popped[k] : 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
      mem_q.delete(); infl.delete(); mfifo.delete();
      m_fetch_pc = 32'h0; m_run = 1'b1; m_mis = 1'b0; last_due = cyc;
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock: drive inputs, advance, update the reference, compare outputs.
   // rmode: 0 no redirect, 1 redirect, 2 redirect only when a response and a pop coincide.
   task automatic cycle(input bit rdy, input int rmode, input logic [31:0] rpc);
      bit g, p, r, redir;
      logic [31:0] ga, pid, fpc;
      int unsigned due;
      flight_t fe;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      id_ready = rdy;
      r = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
      imem_rvalid = r;
      imem_rdata  = r ? mem_word(mem_q[0].addr) : $urandom;
      redir = (rmode == 1) || ((rmode == 2) && r && id_valid && rdy);
      fired = redir;
      redirect = redir;
      redirect_pc = rpc;
      g = imem_req && imem_gnt; ga = imem_addr;
      p = id_valid && id_ready; pid = id_pc;
      @(posedge clk);
      #1;
      cyc++;
      if (g) begin
         chk("grant_addr", ga, m_fetch_pc);
         dut_grants.push_back(ga);
         due = cyc + $urandom_range(max_lat, min_lat);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: ga, due: due});
         infl.push_back('{pc: m_fetch_pc, stale: 1'b0});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (p && !redir) begin
         popped.push_back(pid);
         if (mfifo.size() > 0) void'(mfifo.pop_front());
      end
      if (r) begin
         void'(mem_q.pop_front());
         if (infl.size() > 0) begin
            fe = infl.pop_front();
            if (!fe.stale && !redir) mfifo.push_back(fe.pc);
         end
      end
      if (redir) begin
         mfifo.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
         fpc = rpc;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (fpc[1:0] != 2'b00) begin m_mis = 1'b1; m_run = 1'b0; end
         else m_run = 1'b1;
`else
         fpc[1:0] = 2'b00;
`endif
         m_fetch_pc = fpc;
      end
      chk("id_valid", 32'(id_valid), 32'(mfifo.size() != 0));
      if (mfifo.size() != 0) begin
         chk("id_pc", id_pc, mfifo[0]);
         chk("id_instr", id_instr, mem_word(mfifo[0]));
      end
      chk("imem_req", 32'(imem_req), 32'(m_run && ((mfifo.size() + infl.size()) < DEPTH)));
      chk("imem_addr", imem_addr, m_fetch_pc);
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
   endtask

   initial begin
      // Reset state and single-cycle memory streaming.
      #12;
      do_reset();
      popped.delete();
      repeat (8) cycle(1'b1, 0, 32'h0);
      chk("stream_pops", 32'(popped.size()), 32'd5);
      chk("stream_pc0", pop_at(0), 32'h0);
      chk("stream_pc1", pop_at(1), 32'h4);
      chk("stream_pc2", pop_at(2), 32'h8);
      chk("stream_pc3", pop_at(3), 32'hC);

      // Decode stalled: exactly DEPTH grants, then fetch resumes at 16.
      do_reset();
      dut_grants.delete();
      repeat (10) cycle(1'b0, 0, 32'h0);
      chk("stall_grants", 32'(dut_grants.size()), 32'd4);
      chk("stall_req_low", 32'(imem_req), 32'd0);
      chk("stall_head_pc", id_pc, 32'h0);
      repeat (6) cycle(1'b1, 0, 32'h0);
      chk("resume_addr", (dut_grants.size() > 4) ? dut_grants[4] : 32'hxxxx_xxxx, 32'h10);

      // Redirect with two requests in flight on a 3-cycle memory.
      do_reset();
      min_lat = 3; max_lat = 3;
      repeat (3) cycle(1'b1, 0, 32'h0);
      chk("inflight_two", 32'(infl.size()), 32'd2);
      cycle(1'b1, 1, 32'h100);
      popped.delete();
      repeat (12) cycle(1'b1, 0, 32'h0);
      chk("redir_first_pc", pop_at(0), 32'h100);
      chk("redir_second_pc", pop_at(1), 32'h104);

      // Redirect coinciding with a response and a decode pop.
      min_lat = 1; max_lat = 1;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 2, 32'h240);
         if (fired) break;
      end
      chk("coinc_fired", 32'(fired), 32'd1);
      chk("coinc_empty", 32'(id_valid), 32'd0);
      chk("coinc_addr", imem_addr, 32'h240);
      popped.delete();
      repeat (6) cycle(1'b1, 0, 32'h0);
      chk("coinc_next_pc", pop_at(0), 32'h240);

      // Address wrap at the top of memory.
      cycle(1'b1, 1, 32'hFFFF_FFF8);
      popped.delete();
      repeat (8) cycle(1'b1, 0, 32'h0);
      chk("wrap_pc0", pop_at(0), 32'hFFFF_FFF8);
      chk("wrap_pc1", pop_at(1), 32'hFFFF_FFFC);
      chk("wrap_pc2", pop_at(2), 32'h0000_0000);

      // Misaligned redirect.
      cycle(1'b1, 1, 32'h102);
      popped.delete();
      repeat (6) cycle(1'b1, 0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_flag", 32'(misalign_err), 32'd1);
      chk("mis_halt", 32'(imem_req), 32'd0);
      chk("mis_no_pops", 32'(popped.size()), 32'd0);
      cycle(1'b1, 1, 32'h200);
      popped.delete();
      repeat (6) cycle(1'b1, 0, 32'h0);
      chk("mis_resume_pc", pop_at(0), 32'h200);
      chk("mis_sticky", 32'(misalign_err), 32'd1);
`else
      chk("mis_aligned_pc", pop_at(0), 32'h100);
      chk("mis_flag_zero", 32'(misalign_err), 32'd0);
`endif

      // Reset in the middle of traffic clears everything.
      min_lat = 1; max_lat = 3; gnt_pct = 60;
      repeat (5) cycle(1'b0, 0, 32'h0);
      do_reset();

      // Randomized traffic with occasional redirects.
      min_lat = 1; max_lat = 4; gnt_pct = 70;
      for (int i = 0; i < 800; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : $urandom;
         cycle($urandom_range(99) < 75, ($urandom_range(99) < 4) ? 1 : 0, rpc);
      end
      gnt_pct = 100;
      repeat (20) cycle(1'b1, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
